// File: rtl/isp8_bus_pkg.sv
// Shared encodings and helpers for the isp8 external bus controller.
package isp8_bus_pkg;

  typedef enum logic [1:0] {
    OP_IO_RD  = 2'b00,
    OP_IO_WR  = 2'b01,
    OP_MEM_RD = 2'b10,
    OP_MEM_WR = 2'b11
  } op_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_STROBE = 2'b10
  } state_e;

  localparam int unsigned SETUP_CNT_W = 4;

  // Counter must hold setup/min values (4 bits) and reach TIMEOUT.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w > SETUP_CNT_W) ? w : SETUP_CNT_W;
  endfunction

  // One-hot strobe vector: bit0 io_rd, bit1 io_wr, bit2 mem_rd, bit3 mem_wr.
  function automatic logic [3:0] strobe_vec(input op_kind_e kind);
    return 4'b0001 << kind;
  endfunction

  function automatic logic is_write(input op_kind_e kind);
    return kind[0];
  endfunction

endpackage

// File: rtl/isp8_bus_wait_cnt.sv
// Shared setup/strobe cycle counter; value is the 1-based cycle number in the current phase.
module isp8_bus_wait_cnt #(
  parameter int unsigned CW         = 8,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_MIN = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_inc,
  output logic o_setup_end,
  output logic o_min_met,
  output logic o_timeout_hit
);

  logic [CW-1:0] r_cnt;

  // Saturates so min_met stays true on long waits when timeout is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(1);
    end else if (i_inc && (r_cnt != {CW{1'b1}})) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_setup_end   = (r_cnt == CW'(SETUP_CYC));
  assign o_min_met     = (r_cnt >= CW'(STROBE_MIN));
  assign o_timeout_hit = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

endmodule

// File: rtl/isp8_ext_bus_ctrl.sv
// External io/mem bus controller: address setup, minimum strobe width,
// ext_ready wait-states and timeout termination for one core operation at a time.
module isp8_ext_bus_ctrl
  import isp8_bus_pkg::*;
#(
  parameter int unsigned PORT_AW    = 8,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_MIN = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [1:0]         op_kind,
  input  logic               op_direct,
  input  logic [4:0]         addr_rb,
  input  logic [PORT_AW-1:0] op_reg_addr,
  input  logic [7:0]         op_wdata,
  output logic               op_ready,
  output logic               done,
  output logic               err_timeout,
  output logic [7:0]         rdata,
  output logic [PORT_AW-1:0] ext_addr,
  output logic [7:0]         ext_dout,
  input  logic [7:0]         ext_din,
  input  logic               ext_ready,
  output logic               ext_io_rd,
  output logic               ext_io_wr,
  output logic               ext_mem_rd,
  output logic               ext_mem_wr
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  if (PORT_AW < 5 || PORT_AW > 16) begin : g_bad_aw
    $error("isp8_ext_bus_ctrl: PORT_AW out of range 5..16");
  end
  if (SETUP_CYC > 15 || STROBE_MIN < 1 || STROBE_MIN > 15) begin : g_bad_cyc
    $error("isp8_ext_bus_ctrl: SETUP_CYC or STROBE_MIN out of range");
  end
  if (TIMEOUT != 0 && TIMEOUT <= STROBE_MIN) begin : g_bad_to
    $error("isp8_ext_bus_ctrl: TIMEOUT must exceed STROBE_MIN");
  end

  state_e     r_state;
  op_kind_e   r_kind;
  logic [3:0] r_strobe;
  logic       w_setup_end, w_min_met, w_timeout_hit;
  logic       w_accept, w_load, w_inc, w_term_ok, w_term_to;

  assign op_ready   = (r_state == ST_IDLE) && !rst;
  assign w_accept   = (r_state == ST_IDLE) && op_valid;
  assign w_load     = w_accept || ((r_state == ST_SETUP) && w_setup_end);
  assign w_inc      = (r_state != ST_IDLE);
  assign w_term_ok  = (r_state == ST_STROBE) && w_min_met && ext_ready;
  assign w_term_to  = (r_state == ST_STROBE) && w_timeout_hit && !ext_ready;

  assign ext_io_rd  = r_strobe[0];
  assign ext_io_wr  = r_strobe[1];
  assign ext_mem_rd = r_strobe[2];
  assign ext_mem_wr = r_strobe[3];

  isp8_bus_wait_cnt #(
    .CW         (CW),
    .SETUP_CYC  (SETUP_CYC),
    .STROBE_MIN (STROBE_MIN),
    .TIMEOUT    (TIMEOUT)
  ) u_wait_cnt (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_inc         (w_inc),
    .o_setup_end   (w_setup_end),
    .o_min_met     (w_min_met),
    .o_timeout_hit (w_timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_kind      <= OP_IO_RD;
      r_strobe    <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      rdata       <= '0;
      ext_addr    <= '0;
      ext_dout    <= '0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            r_kind   <= op_kind_e'(op_kind);
            ext_addr <= op_direct ? PORT_AW'(addr_rb) : op_reg_addr;
            if (is_write(op_kind_e'(op_kind))) ext_dout <= op_wdata;
            if (SETUP_CYC == 0) begin
              r_state  <= ST_STROBE;
              r_strobe <= strobe_vec(op_kind_e'(op_kind));
            end else begin
              r_state  <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (w_setup_end) begin
            r_state  <= ST_STROBE;
            r_strobe <= strobe_vec(r_kind);
          end
        end
        ST_STROBE: begin
          // ext_ready on the timeout edge counts as a normal completion.
          if (w_term_ok || w_term_to) begin
            r_state     <= ST_IDLE;
            r_strobe    <= '0;
            done        <= 1'b1;
            err_timeout <= w_term_to;
            if (!is_write(r_kind)) rdata <= w_term_ok ? ext_din : 8'hFF;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_strobe <= '0;
        end
      endcase
    end
  end

endmodule
